// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, engine states
// and the op-code width used by the decoder and the unit.
package hilo_pkg;

   localparam int HILO_OP_W = 3;

   typedef enum logic [HILO_OP_W-1:0] {
      HILO_NONE  = 3'd0,
      HILO_MULT  = 3'd1,
      HILO_MULTU = 3'd2,
      HILO_DIV   = 3'd3,
      HILO_DIVU  = 3'd4,
      HILO_MTHI  = 3'd5,
      HILO_MTLO  = 3'd6
   } hilo_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } hilo_state_e;

endpackage

// File: rtl/div_iter.sv
// Radix-2 restoring divider core on unsigned magnitudes: one quotient bit per
// cycle for DATA_W cycles, then valid_o for one cycle with the final result.
module div_iter #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [DATA_W-1:0] dividend_i,
   input  logic [DATA_W-1:0] divisor_i,
   output logic [DATA_W-1:0] quotient_o,
   output logic [DATA_W-1:0] remainder_o,
   output logic              valid_o
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] rem_q, rem_d;
   logic [DATA_W-1:0] quo_q, quo_d;
   logic [DATA_W-1:0] dvs_q, dvs_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              run_q, run_d;
   logic [DATA_W:0]   shifted;
   logic [DATA_W-1:0] diff;
   logic              fits;
   logic              lastCycle;

   // The quotient register doubles as the dividend shift register, so each
   // iteration shifts its MSB into the partial remainder.
   always_comb begin
      shifted   = {rem_q, quo_q[DATA_W-1]};
      diff      = shifted[DATA_W-1:0] - dvs_q;
      fits      = (shifted >= {1'b0, dvs_q});
      lastCycle = run_q && (cnt_q == CNT_W'(DATA_W));
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      cnt_d     = cnt_q;
      run_d     = run_q;
      if (abort_i) begin
         run_d = 1'b0;
      end else if (start_i) begin
         rem_d = '0;
         quo_d = dividend_i;
         dvs_d = divisor_i;
         cnt_d = '0;
         run_d = 1'b1;
      end else if (run_q) begin
         if (lastCycle) begin
            run_d = 1'b0;
         end else begin
            cnt_d = cnt_q + 1'b1;
            quo_d = {quo_q[DATA_W-2:0], fits};
            rem_d = fits ? diff : shifted[DATA_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;
   assign valid_o     = lastCycle;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register file with a multi-cycle multiply/divide engine.
// Optional HILO_BYPASS_EN forwards the value being written onto hi_out/lo_out.
module hilo_muldiv_unit
   import hilo_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int MUL_LAT = 2
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 op_valid,
   input  logic [HILO_OP_W-1:0] op,
   input  logic [DATA_W-1:0]    src_a,
   input  logic [DATA_W-1:0]    src_b,
   input  logic                 flush,
   output logic                 busy,
   output logic                 done,
   output logic [DATA_W-1:0]    hi_out,
   output logic [DATA_W-1:0]    lo_out
);

   localparam int CNT_W  = $clog2(MUL_LAT + 1);
   localparam int PROD_W = 2 * DATA_W;

   hilo_op_e          opCode;
   hilo_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;
   logic              busy_q;
   logic              accept;
   logic              mulSigned;
   logic [PROD_W-1:0] mulA, mulB;
   logic [PROD_W-1:0] mulPipe_q [MUL_LAT];
   logic              mulFinal;
   logic              divSigned;
   logic              divStart;
   logic              divAbort;
   logic              divValid;
   logic              aNeg, bNeg;
   logic [DATA_W-1:0] absA, absB;
   logic [DATA_W-1:0] divQuo, divRem;
   logic [DATA_W-1:0] quoFix, remFix;
   logic              divNegQ_q, divNegR_q, divZero_q;
   logic [DATA_W-1:0] divSrcA_q;

   assign opCode = hilo_op_e'(op);
   assign accept = op_valid && (state_q == IDLE) && !flush;

   assign mulSigned = (opCode == HILO_MULT);
   assign mulA = mulSigned ? {{DATA_W{src_a[DATA_W-1]}}, src_a} : {{DATA_W{1'b0}}, src_a};
   assign mulB = mulSigned ? {{DATA_W{src_b[DATA_W-1]}}, src_b} : {{DATA_W{1'b0}}, src_b};

   // Stage 0 captures the product of the presented operands every cycle; only
   // the entry that reaches the tail in the final MUL cycle is ever used.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < MUL_LAT; i++) mulPipe_q[i] <= '0;
      end else begin
         mulPipe_q[0] <= mulA * mulB;
         for (int i = 1; i < MUL_LAT; i++) mulPipe_q[i] <= mulPipe_q[i-1];
      end
   end

   assign divSigned = (opCode == HILO_DIV);
   assign aNeg      = divSigned && src_a[DATA_W-1];
   assign bNeg      = divSigned && src_b[DATA_W-1];
   assign absA      = aNeg ? (~src_a + 1'b1) : src_a;
   assign absB      = bNeg ? (~src_b + 1'b1) : src_b;
   assign divAbort  = (state_q == DIV) && flush;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         divNegQ_q <= 1'b0;
         divNegR_q <= 1'b0;
         divZero_q <= 1'b0;
         divSrcA_q <= '0;
      end else if (divStart) begin
         divNegQ_q <= aNeg ^ bNeg;
         divNegR_q <= aNeg;
         divZero_q <= (src_b == '0);
         divSrcA_q <= src_a;
      end
   end

   div_iter #(.DATA_W(DATA_W)) u_div_iter (
      .clk         (clk),
      .resetn      (resetn),
      .start_i     (divStart),
      .abort_i     (divAbort),
      .dividend_i  (absA),
      .divisor_i   (absB),
      .quotient_o  (divQuo),
      .remainder_o (divRem),
      .valid_o     (divValid)
   );

   // MIN / -1 needs no special case: |MIN| / 1 gives MIN, rem 0, positive sign.
   assign quoFix   = divNegQ_q ? (~divQuo + 1'b1) : divQuo;
   assign remFix   = divNegR_q ? (~divRem + 1'b1) : divRem;
   assign mulFinal = (state_q == MUL) && (cnt_q == CNT_W'(MUL_LAT));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      divStart = 1'b0;
      done     = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               case (opCode)
                  HILO_MULT, HILO_MULTU: begin
                     state_d = MUL;
                     cnt_d   = CNT_W'(1);
                  end
                  HILO_DIV, HILO_DIVU: begin
                     state_d  = DIV;
                     divStart = 1'b1;
                  end
                  HILO_MTHI: hi_d = src_a;
                  HILO_MTLO: lo_d = src_a;
                  default: ;
               endcase
            end
         end
         MUL: begin
            if (flush) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (mulFinal) begin
               state_d = IDLE;
               cnt_d   = '0;
               hi_d    = mulPipe_q[MUL_LAT-1][PROD_W-1:DATA_W];
               lo_d    = mulPipe_q[MUL_LAT-1][DATA_W-1:0];
               done    = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DIV: begin
            if (flush) begin
               state_d = IDLE;
            end else if (divValid) begin
               state_d = IDLE;
               hi_d    = divZero_q ? divSrcA_q : remFix;
               lo_d    = divZero_q ? '1 : quoFix;
               done    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= (state_d != IDLE);
      end
   end

   assign busy = busy_q;

`ifdef HILO_BYPASS_EN
   assign hi_out = hi_d;
   assign lo_out = lo_d;
`else
   assign hi_out = hi_q;
   assign lo_out = lo_q;
`endif

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
Parametrised HI/LO register file with an attached multi-cycle multiply/divide engine. It executes the HI/LO-class ops that the main decoder flags: MULT, MULTU, DIV, DIVU, MTHI and MTLO. The unit sits beside the EX stage and exposes a busy signal that the hazard unit uses to stall MFHI/MFLO and further HI/LO ops. It replaces the single-cycle HI/LO write path and adds configurable data width and multiply latency.

Parameters:
DATA_W, 32, operand width; HI and LO are each DATA_W bits; must be even and ≥ 8.
MUL_LAT, 2, multiply latency in cycles; must be ≥ 1.

Ports:
clk  in  1  clock, rising edge.
resetn  in  1  asynchronous active-low reset.
op_valid  in  1  op present this cycle.
op  in  3  hilo_op code, defined in the shared package.
src_a  in  DATA_W  rs value (dividend, multiplicand, MTHI/MTLO data).
src_b  in  DATA_W  rt value (divisor, multiplier).
flush  in  1  abort any in-flight or presented op.
busy  out  1  engine occupied; upstream must hold its op and stall.
done  out  1  one-cycle pulse in the cycle a mul/div result is written.
hi_out  out  DATA_W  current HI.
lo_out  out  DATA_W  current LO.

Behaviour:
- Reset: asynchronous on resetn low. State goes to IDLE; HI, LO and the counter clear to 0; busy=0; done=0.
- States: IDLE, MUL, DIV. busy = (state != IDLE), driven from a register.
- Acceptance: an op is accepted only when op_valid=1, state is IDLE and flush=0. When busy=1, op_valid is ignored.
- Op code HILO_NONE, or any unused code, is a no-op.
- MTHI/MTLO: HI (or LO) takes src_a at the end of the acceptance cycle. busy never rises. done stays 0.
- MULT/MULTU, accepted in cycle t:
  - Operands are latched at t.
  - busy is high in cycles t+1 .. t+MUL_LAT.
  - The full 2*DATA_W product is written at the end of cycle t+MUL_LAT: HI = upper half, LO = lower half.
  - done is high in cycle t+MUL_LAT.
  - MULT is signed two's complement; MULTU is unsigned.
- DIV/DIVU, accepted in cycle t:
  - At t: latch operand magnitudes (signed ops take absolute values) and the result signs.
  - Cycles t+1 .. t+DATA_W: radix-2 restoring iterations, one quotient bit per cycle.
  - Cycle t+DATA_W+1: sign fix-up and write. LO = quotient; HI = remainder, which takes the dividend's sign.
  - busy is high in cycles t+1 .. t+DATA_W+1; done is high in cycle t+DATA_W+1.
- Divide by zero (both signed and unsigned): LO = all ones; HI = src_a unchanged. Latency is the same as a normal divide.
- Signed overflow, most-negative / -1: LO = most-negative value, HI = 0.
- New HI/LO values are visible on hi_out/lo_out from the cycle after the write.
- flush:
  - In IDLE: discards the presented op.
  - In MUL/DIV: state returns to IDLE at the next edge. busy drops the next cycle, HI/LO keep their old values, done is not asserted.
  - flush coinciding with the final busy cycle suppresses that write.
- A new op may be accepted in the first cycle with busy=0, so back-to-back ops have no dead cycle beyond the busy period.

Optional Feature:
HILO_BYPASS_EN
- Defined: hi_out/lo_out combinationally forward the value being written this cycle. This covers an MTHI/MTLO accept and the done cycle of a mul/div, and gives zero-cycle visibility. busy is unchanged.
- Undefined: hi_out/lo_out are pure register outputs, so a new value appears one cycle after the write.

Decomposition:
- Shared package hilo_pkg, holding:
  - op codes: HILO_NONE=0, HILO_MULT=1, HILO_MULTU=2, HILO_DIV=3, HILO_DIVU=4, HILO_MTHI=5, HILO_MTLO=6;
  - state encodings IDLE/MUL/DIV;
  - the hilo_op width constant.
- Sub-module div_iter: restoring divider core with start/abort inputs, DATA_W-cycle iteration, and quotient/remainder/valid outputs.
- The multiply is a MUL_LAT-deep registered pipeline inside the top module.

Test Plan (DATA_W=32, MUL_LAT=2):
- MTHI 0xDEADBEEF, then MTLO 0x12345678 → hi_out=0xDEADBEEF and lo_out=0x12345678, each visible one cycle after its write; busy stays 0.
- MULT 0xFFFFFFFE×3 → 2 busy cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV 0xFFFFFFF9 (-7) / 2 → 33 busy cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with the same operands → LO=0x7FFFFFFC, HI=0x00000001.
- DIV 100/0 → HI=0x00000064, LO=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIV accepted, flush on the 10th busy cycle → busy=0 next cycle, no done, HI/LO unchanged. A MULT presented the next cycle is accepted.
- resetn pulsed low mid-DIV → busy, done, HI and LO all 0 immediately (asynchronous), with no write after reset release.
